fetch_cycle: RTL and testbench
==============================

Name: fetch_cycle

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It feeds decode_cycle with InstrD, PCD and PCPlus4D.
- Owns the PC and talks to instruction memory over a single-outstanding request/response handshake.
- Buffers one returned instruction while the pipeline is stalled by o_p_waitrequest.
- Handles branch/jump redirects from Execute, flushing in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on InstrD when no valid instruction

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
o_p_waitrequest  input  1  pipeline stall; IF/ID register holds while 1
PCSrcE  input  1  redirect request from Execute (taken branch/jump)
PCTargetE  input  32  redirect target
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (word aligned)
imem_ready  input  1  memory accepts request when imem_req & imem_ready
imem_rvalid  input  1  response valid, 1+ cycles after acceptance
imem_rdata  input  32  returned instruction
InstrD  output  32  instruction to decode
PCD  output  32  PC of InstrD
PCPlus4D  output  32  PCD + 4 (mod 2^32)
ValidD  output  1  InstrD is a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst=1):
  - State = REQ, pc_q = RESET_PC, kill = 0, hold buffer empty.
  - InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0.
  - imem_req = 0 while rst is high.
  - Reset mid-transaction drops the outstanding request. Any imem_rvalid arriving with no outstanding request is ignored.
- FSM states: REQ, WAIT, HOLD.
  - REQ: imem_req = 1, imem_addr = pc_q. On acceptance: pc_q += 4, go to WAIT.
  - WAIT: on imem_rvalid:
    - kill = 1: discard the response, clear kill, go to REQ.
    - else if o_p_waitrequest = 0: load the IF/ID register with {imem_rdata, fetched PC, ValidD = 1}. In the same cycle assert imem_req for pc_q (back-to-back). Go to WAIT if accepted, else REQ.
    - else: store instr/PC in the hold buffer, go to HOLD.
  - HOLD: imem_req = 0. When o_p_waitrequest = 0, load the IF/ID register from the buffer, go to REQ.
- Bubble: IF/ID loads {NOP_INSTR, ValidD = 0} when o_p_waitrequest = 0 and no instruction is available that cycle. PCD/PCPlus4D hold their previous values on a bubble.
- Stall: while o_p_waitrequest = 1, the IF/ID register and PCSrcE handling are frozen. Requests still issue from REQ.
- Redirect: acted on only when PCSrcE = 1 and o_p_waitrequest = 0. Redirect has priority over any load.
  - IF/ID <= {NOP_INSTR, ValidD = 0}, pc_q <= PCTargetE.
  - Hold buffer discarded; HOLD goes to REQ.
  - If a request is outstanding (WAIT with no rvalid this cycle), set kill. If rvalid arrives in the same cycle, discard it directly and go to REQ.
  - A request being accepted in the same cycle is also marked kill.
- Performance: with imem_ready = 1 and 1-cycle response latency, throughput is 1 instruction/cycle after the first 2-cycle fill. PC wraps modulo 2^32.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs fetch_stall_cnt[31:0] and fetch_flush_cnt[31:0], both reset to 0, saturating at 32'hFFFF_FFFF.
  - fetch_stall_cnt increments each cycle o_p_waitrequest = 0 and a bubble is loaded.
  - fetch_flush_cnt increments on each acted-on redirect.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Reset then release, imem_ready = 1, 1-cycle rvalid returning 32'h00500093 @0, 32'h00A00113 @4 -> imem_addr 0, 4, 8 on consecutive cycles; ValidD = 1 with PCD = 0 then 4; PCPlus4D = 4 then 8.
- o_p_waitrequest = 1 for 3 cycles while rvalid returns instruction @8 -> enters HOLD, IF/ID frozen, imem_req = 0. On release, InstrD = that instruction, PCD = 8, next imem_addr = 12.
- PCSrcE = 1, PCTargetE = 32'h100 while request @16 is outstanding -> IF/ID = NOP_INSTR with ValidD = 0; response for 16 discarded; next imem_addr = 32'h100; first valid PCD = 32'h100.
- Same redirect asserted with o_p_waitrequest = 1 -> no effect until stall drops; then redirect taken exactly once.
- imem_ready = 0 for 4 cycles -> imem_req held with imem_addr stable; bubbles (ValidD = 0) loaded each unstalled cycle.
- Assert rst during WAIT, then deliver stray rvalid -> stray response ignored; first request after release is RESET_PC; all outputs at reset values during rst.

Source files
------------

// File: rtl/fetch_cycle.sv
// -----------------------------------------------------------------------------
// fetch_cycle
// Instruction-fetch stage plus IF/ID pipeline register feeding decode.
// Owns the PC. Talks to instruction memory over a single-outstanding
// request/response handshake. Buffers one returned instruction while decode is
// stalled. Flushes in-flight and buffered instructions on an Execute redirect.
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//   NOP_INSTR  bubble instruction driven on InstrD when ValidD = 0
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   o_p_waitrequest   pipeline stall; IF/ID register and redirects frozen while 1
//   PCSrcE/PCTargetE  redirect request and target from Execute
//   imem_req/addr     fetch request valid and word-aligned address
//   imem_ready        request accepted when imem_req & imem_ready
//   imem_rvalid/rdata response valid and returned instruction
//   InstrD/PCD/PCPlus4D/ValidD  IF/ID register contents
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   fetch_stall_cnt   saturating count of unstalled cycles that load a bubble
//   fetch_flush_cnt   saturating count of redirects acted on
// -----------------------------------------------------------------------------
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        o_p_waitrequest,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_stall_cnt,
  output logic [31:0] fetch_flush_cnt
`endif
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic [XLEN-1:0] instr_q, pcd_q, pcp4_q;
  logic            valid_q;

  logic            stall;
  logic            redirect;
  logic            req_c;
  logic            load_instr;
  logic            load_bubble;
  logic [XLEN-1:0] new_instr;
  logic [XLEN-1:0] new_pc;

  assign stall    = o_p_waitrequest;
  // Redirects are frozen along with the IF/ID register during a stall.
  assign redirect = PCSrcE & ~stall;

  // Next-state, PC and IF/ID load decisions.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    fetch_pc_d   = fetch_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    req_c        = 1'b0;
    load_instr   = 1'b0;
    new_instr    = imem_rdata;
    new_pc       = fetch_pc_q;

    unique case (state_q)
      ST_REQ: begin
        req_c = 1'b1;
        if (imem_ready) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + XLEN'(4);
          // A request accepted alongside a redirect fetches the stale path.
          kill_d     = redirect;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else if (redirect) begin
            state_d = ST_REQ;
          end else if (!stall) begin
            load_instr = 1'b1;
            // Back-to-back fetch: pc_q already points at the next word.
            req_c      = 1'b1;
            if (imem_ready) begin
              fetch_pc_d = pc_q;
              pc_d       = pc_q + XLEN'(4);
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = fetch_pc_q;
            state_d      = ST_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (!stall) begin
          load_instr = 1'b1;
          new_instr  = hold_instr_q;
          new_pc     = hold_pc_q;
          state_d    = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    if (redirect) begin
      pc_d = PCTargetE;
    end
  end

  // load_instr is never set on a redirect, so a redirect always yields a bubble.
  assign load_bubble = ~stall & ~load_instr;

  // Fetch state, PC, kill flag and hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      fetch_pc_q   <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      fetch_pc_q   <= fetch_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // IF/ID register; PCD/PCPlus4D keep their last values across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_instr) begin
      instr_q <= new_instr;
      pcd_q   <= new_pc;
      pcp4_q  <= new_pc + XLEN'(4);
      valid_q <= 1'b1;
    end else if (load_bubble) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

  assign imem_req  = req_c & ~rst;
  assign imem_addr = pc_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcp4_q;
  assign ValidD    = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] stall_cnt_q;
  logic [XLEN-1:0] flush_cnt_q;

  // Saturating bubble and redirect counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_bubble && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + XLEN'(1);
      end
      if (redirect && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + XLEN'(1);
      end
    end
  end

  assign fetch_stall_cnt = stall_cnt_q;
  assign fetch_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// -----------------------------------------------------------------------------
// tb_fetch_cycle
// Directed scenarios followed by a randomized run. The random run checks the
// decode-side instruction stream against a program-order model: every valid
// instruction must be the next sequential PC (restarting at the target after
// each acted-on redirect) with the memory word at that address.
// -----------------------------------------------------------------------------
module tb_fetch_cycle;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pcsrc;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr_d;
  logic [31:0] pcd;
  logic [31:0] pcp4d;
  logic        validd;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  fetch_cycle #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .o_p_waitrequest(stall), .PCSrcE(pcsrc), .PCTargetE(tgt),
    .imem_req(req), .imem_addr(addr), .imem_ready(ready), .imem_rvalid(rvalid),
    .imem_rdata(rdata), .InstrD(instr_d), .PCD(pcd), .PCPlus4D(pcp4d), .ValidD(validd)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_stall_cnt(stall_cnt), .fetch_flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  int          lat;
  bit          pend;
  int          wait_n;
  logic [31:0] pend_addr;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  // Advance one clock and play the memory: a response follows 'lat' cycles
  // after each accepted request.
  task automatic step();
    bit          acc;
    logic [31:0] a;
    #1;
    acc = req & ready;
    a   = addr;
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    if (acc) begin
      pend = 1'b1; wait_n = lat; pend_addr = a;
    end
    if (pend) begin
      wait_n--;
      if (wait_n == 0) begin
        rvalid = 1'b1; rdata = mem_at(pend_addr); pend = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; tgt = '0; ready = 1'b1;
    rvalid = 1'b0; rdata = '0; pend = 1'b0; lat = 1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; tgt = '0; ready = 1'b1;
    rvalid = 1'b0; rdata = '0; pend = 1'b0; lat = 1;
    step(); step();
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++; if (instr_d !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instr_d, NOP); end
    checks++; if (pcd !== 32'h0) begin errors++; $display("FAIL reset_pcd: got %h want 0", pcd); end
    checks++; if (pcp4d !== 32'h0) begin errors++; $display("FAIL reset_pcp4: got %h want 0", pcp4d); end
    checks++; if (validd !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", validd); end
    rst = 1'b0;
  endtask

  task automatic test_fill_and_hold();
    lat = 1; ready = 1'b1; stall = 1'b0;
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'h0) begin errors++; $display("FAIL fill_addr0: got req=%b addr=%h want 1/0", req, addr); end
    step(); #1;
    checks++; if (req !== 1'b1 || addr !== 32'h4) begin errors++; $display("FAIL fill_addr4: got req=%b addr=%h want 1/4", req, addr); end
    step();
    checks++; if (validd !== 1'b1 || pcd !== 32'h0 || pcp4d !== 32'h4 || instr_d !== 32'h00500093) begin
      errors++; $display("FAIL fill_first: got v=%b pc=%h p4=%h i=%h want 1/0/4/00500093", validd, pcd, pcp4d, instr_d); end
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'h8) begin errors++; $display("FAIL fill_addr8: got req=%b addr=%h want 1/8", req, addr); end
    step();
    checks++; if (validd !== 1'b1 || pcd !== 32'h4 || pcp4d !== 32'h8 || instr_d !== 32'h00A00113) begin
      errors++; $display("FAIL fill_second: got v=%b pc=%h p4=%h i=%h want 1/4/8/00A00113", validd, pcd, pcp4d, instr_d); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %b want 0", i, req); end
      step();
      checks++; if (pcd !== 32'h4 || instr_d !== 32'h00A00113 || validd !== 1'b1) begin
        errors++; $display("FAIL hold_frozen[%0d]: got pc=%h i=%h v=%b want 4/00A00113/1", i, pcd, instr_d, validd); end
    end
    stall = 1'b0;
    step();
    checks++; if (validd !== 1'b1 || pcd !== 32'h8 || instr_d !== mem_at(32'h8)) begin
      errors++; $display("FAIL hold_release: got v=%b pc=%h i=%h want 1/8/%h", validd, pcd, instr_d, mem_at(32'h8)); end
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'hC) begin errors++; $display("FAIL hold_next_addr: got req=%b addr=%h want 1/c", req, addr); end
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    lat = 2;
    for (int i = 0; i < 12 && !found; i++) begin
      #1;
      if (req && ready && addr == 32'h10) found = 1'b1;
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL redir_accept16: got none want request @10"); end
    pcsrc = 1'b1; tgt = 32'h100;
    step();
    pcsrc = 1'b0;
    checks++; if (validd !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL redir_bubble: got v=%b i=%h want 0/%h", validd, instr_d, NOP); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (req) found = 1'b1; else step();
    end
    checks++; if (!found || addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got found=%b addr=%h want 1/100", found, addr); end
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (validd) found = 1'b1;
    end
    checks++; if (!found || pcd !== 32'h100 || instr_d !== mem_at(32'h100)) begin
      errors++; $display("FAIL redir_first: got pc=%h i=%h want 100/%h", pcd, instr_d, mem_at(32'h100)); end
  endtask

  task automatic test_redirect_stalled();
    logic [31:0] p_pc, p_i;
    logic        p_v;
    bit          found;
    p_pc = pcd; p_i = instr_d; p_v = validd;
    stall = 1'b1; pcsrc = 1'b1; tgt = 32'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pcd !== p_pc || instr_d !== p_i || validd !== p_v) begin
        errors++; $display("FAIL rstall_frozen[%0d]: got pc=%h i=%h v=%b want %h/%h/%b", i, pcd, instr_d, validd, p_pc, p_i, p_v); end
    end
    stall = 1'b0;
    step();
    pcsrc = 1'b0;
    checks++; if (validd !== 1'b0) begin errors++; $display("FAIL rstall_bubble: got v=%b want 0", validd); end
    for (int k = 0; k < 2; k++) begin
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        step();
        if (validd) found = 1'b1;
      end
      checks++; if (!found || pcd !== 32'h200 + 32'(4 * k)) begin
        errors++; $display("FAIL rstall_stream[%0d]: got pc=%h want %h", k, pcd, 32'h200 + 32'(4 * k)); end
    end
  endtask

  task automatic test_ready_low();
    logic [31:0] a;
    ready = 1'b0;
    repeat (3) step();
    #1;
    a = addr;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req !== 1'b1 || addr !== a) begin errors++; $display("FAIL rdy_hold[%0d]: got req=%b addr=%h want 1/%h", i, req, addr, a); end
      step();
      checks++; if (validd !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL rdy_bubble[%0d]: got v=%b i=%h want 0/%h", i, validd, instr_d, NOP); end
    end
    ready = 1'b1;
  endtask

  task automatic test_throughput();
    do_reset();
    repeat (2) step();
    for (int i = 0; i < 16; i++) begin
      checks++; if (validd !== 1'b1 || pcd !== 32'(4 * i)) begin
        errors++; $display("FAIL tput[%0d]: got v=%b pc=%h want 1/%h", i, validd, pcd, 32'(4 * i)); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    lat = 3;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (req && ready) found = 1'b1;
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_accept: got none want accepted request"); end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req !== 1'b0 || validd !== 1'b0 || instr_d !== NOP || pcd !== 32'h0 || pcp4d !== 32'h0) begin
        errors++; $display("FAIL rmid_inreset[%0d]: got req=%b v=%b i=%h pc=%h p4=%h want 0/0/%h/0/0", i, req, validd, instr_d, pcd, pcp4d, NOP); end
      step();
    end
    rst = 1'b0; ready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (req !== 1'b1 || addr !== RESET_PC) begin errors++; $display("FAIL rmid_first_addr: got req=%b addr=%h want 1/%h", req, addr, RESET_PC); end
    step();
    checks++; if (validd !== 1'b0) begin errors++; $display("FAIL rmid_stray: got v=%b i=%h want 0", validd, instr_d); end
    ready = 1'b1; lat = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (validd) found = 1'b1;
    end
    checks++; if (!found || pcd !== RESET_PC || instr_d !== mem_at(RESET_PC)) begin
      errors++; $display("FAIL rmid_first_valid: got pc=%h i=%h want %h/%h", pcd, instr_d, RESET_PC, mem_at(RESET_PC)); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, p_pc, p_p4, p_i, hold_addr;
    logic        p_v, stall_b, redir_b, hold_chk;
    logic [31:0] tgt_b;
    int          delivered = 0;
    do_reset();
    exp_pc = RESET_PC; hold_chk = 1'b0; hold_addr = '0;
    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      pcsrc = ($urandom_range(0, 19) == 0);
      tgt   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      ready = ($urandom_range(0, 3) != 0);
      lat   = int'($urandom_range(1, 3));
      #1;
      if (hold_chk) begin
        checks++; if (req !== 1'b1 || addr !== hold_addr) begin
          errors++; $display("FAIL rnd_req_stable[%0d]: got req=%b addr=%h want 1/%h", n, req, addr, hold_addr); end
      end
      if (req && addr[1:0] != 2'b00) begin
        checks++; errors++; $display("FAIL rnd_align[%0d]: got addr=%h want word aligned", n, addr);
      end
      stall_b = stall; redir_b = pcsrc & ~stall; tgt_b = tgt;
      p_pc = pcd; p_p4 = pcp4d; p_i = instr_d; p_v = validd;
      hold_chk = req & ~ready & ~redir_b; hold_addr = addr;
      step();
      checks++;
      if (redir_b) begin
        if (validd !== 1'b0 || instr_d !== NOP || pcd !== p_pc) begin
          errors++; $display("FAIL rnd_redirect[%0d]: got v=%b i=%h pc=%h want 0/%h/%h", n, validd, instr_d, pcd, NOP, p_pc); end
        exp_pc = tgt_b;
      end else if (stall_b) begin
        if (validd !== p_v || instr_d !== p_i || pcd !== p_pc || pcp4d !== p_p4) begin
          errors++; $display("FAIL rnd_stall[%0d]: got v=%b i=%h pc=%h want %b/%h/%h", n, validd, instr_d, pcd, p_v, p_i, p_pc); end
      end else if (validd) begin
        if (pcd !== exp_pc || instr_d !== mem_at(exp_pc) || pcp4d !== exp_pc + 32'd4) begin
          errors++; $display("FAIL rnd_stream[%0d]: got pc=%h i=%h p4=%h want %h/%h/%h", n, pcd, instr_d, pcp4d, exp_pc, mem_at(exp_pc), exp_pc + 32'd4); end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else begin
        if (instr_d !== NOP || pcd !== p_pc || pcp4d !== p_p4) begin
          errors++; $display("FAIL rnd_bubble[%0d]: got i=%h pc=%h p4=%h want %h/%h/%h", n, instr_d, pcd, pcp4d, NOP, p_pc, p_p4); end
      end
    end
    checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d want >= 200 deliveries", delivered); end
    stall = 1'b0; pcsrc = 1'b0; ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    test_reset();
    test_fill_and_hold();
    test_redirect();
    test_redirect_stalled();
    test_ready_low();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
